// File: rtl/aemb2_ifetch.sv
// ---------------------------------------------------------------------------
// aemb2_ifetch -- AEMB2 instruction fetch unit
//
// Keeps one word-address program counter per hardware thread and drives the
// instruction bus with a single outstanding strobe. Each fetched word is held
// on ich_dat, with its link PC on rpc_if, until decode accepts it. Branches
// resolved in EX redirect the owning thread's PC. A taken branch without a
// delay slot on the held thread squashes the held word and refetches from the
// target.
//
// Ports
//   gclk       in   1   core clock, posedge
//   grst       in   1   synchronous reset, active low
//   iwb_adr_o  out  30  instruction word address
//   iwb_stb_o  out  1   bus request, held until iwb_ack_i
//   iwb_ack_i  in   1   bus acknowledge, iwb_dat_i valid in the same cycle
//   iwb_dat_i  in   32  instruction word
//   ich_dat    out  32  held instruction for decode
//   rpc_if     out  30  word address of ich_dat + 1
//   iena       out  1   ich_dat/rpc_if valid
//   gpha       out  1   thread owning the held instruction
//   dena       in   1   decode accepts the held instruction
//   bra_ex     in   2   [1] branch taken, [0] branch has delay slot
//   bra_thd    in   1   thread owning bra_ex
//   bpc_ex     in   30  branch target word address
// ---------------------------------------------------------------------------
module aemb2_ifetch #(
    parameter bit          AEMB_HTX = 1'b1,
    parameter logic [29:0] RST_VEC0 = 30'h0,
    parameter logic [29:0] RST_VEC1 = 30'h0
) (
    input  logic        gclk,
    input  logic        grst,
    output logic [29:0] iwb_adr_o,
    output logic        iwb_stb_o,
    input  logic        iwb_ack_i,
    input  logic [31:0] iwb_dat_i,
    output logic [31:0] ich_dat,
    output logic [29:0] rpc_if,
    output logic        iena,
    output logic        gpha,
    input  logic        dena,
    input  logic [1:0]  bra_ex,
    input  logic        bra_thd,
    input  logic [29:0] bpc_ex
);

    typedef enum logic [0:0] {
        ST_REQ  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic        live_r;          // low only for the cycle(s) of reset, masks the strobe
    logic [29:0] pc0_r;
    logic [29:0] pc1_r;
    logic [29:0] pc0_nxt_s;
    logic [29:0] pc1_nxt_s;
    logic [29:0] cur_pc_s;
    logic [29:0] cur_pc_inc_s;
    logic        capture_s;
    logic        accept_s;
    logic        bra_take_s;
    logic        bra_same_s;
    logic        squash_s;

    // Event decode: bus capture, decode accept, and branch classification.
    always_comb begin
        cur_pc_s     = gpha ? pc1_r : pc0_r;
        cur_pc_inc_s = cur_pc_s + 30'd1;   // natural 30-bit wrap
        capture_s    = iwb_stb_o & iwb_ack_i;
        accept_s     = (state_r == ST_HOLD) & dena;
        // Branch info is only honoured together with an accept.
        bra_take_s   = accept_s & bra_ex[1];
        bra_same_s   = bra_take_s & (bra_thd == gpha);
        squash_s     = bra_same_s & ~bra_ex[0];
    end

    // State register.
    always_ff @(posedge gclk) begin
        if (!grst) begin
            state_r <= ST_REQ;
            live_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            live_r  <= 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_REQ: begin
                if (capture_s) state_nxt_s = ST_HOLD;
                else           state_nxt_s = ST_REQ;
            end
            ST_HOLD: begin
                if (dena) state_nxt_s = ST_REQ;
                else      state_nxt_s = ST_HOLD;
            end
            default: state_nxt_s = ST_REQ;
        endcase
    end

    // Bus outputs: strobe only in REQ, address from the current thread's PC.
    always_comb begin
        iwb_stb_o = 1'b0;
        iwb_adr_o = cur_pc_s;
        case (state_r)
            ST_REQ:  iwb_stb_o = live_r;
            ST_HOLD: iwb_stb_o = 1'b0;
            default: iwb_stb_o = 1'b0;
        endcase
    end

    // Next PC per thread: the held thread advances or takes its branch target,
    // the other thread only changes when the branch belongs to it.
    always_comb begin
        pc0_nxt_s = pc0_r;
        pc1_nxt_s = pc1_r;
        if (accept_s) begin
            if (!gpha) begin
                pc0_nxt_s = bra_same_s ? bpc_ex : cur_pc_inc_s;
                if (bra_take_s && bra_thd) pc1_nxt_s = bpc_ex;
                else                       pc1_nxt_s = pc1_r;
            end else begin
                pc1_nxt_s = bra_same_s ? bpc_ex : cur_pc_inc_s;
                if (bra_take_s && !bra_thd) pc0_nxt_s = bpc_ex;
                else                        pc0_nxt_s = pc0_r;
            end
        end else begin
            pc0_nxt_s = pc0_r;
            pc1_nxt_s = pc1_r;
        end
    end

    // Program counter registers.
    always_ff @(posedge gclk) begin
        if (!grst) begin
            pc0_r <= RST_VEC0;
            pc1_r <= RST_VEC1;
        end else begin
            pc0_r <= pc0_nxt_s;
            pc1_r <= pc1_nxt_s;
        end
    end

    // Held instruction, link PC, valid flag and thread phase.
    always_ff @(posedge gclk) begin
        if (!grst) begin
            ich_dat <= 32'h0;
            rpc_if  <= 30'h0;
            iena    <= 1'b0;
            gpha    <= 1'b0;
        end else if (capture_s) begin
            ich_dat <= iwb_dat_i;
            rpc_if  <= cur_pc_inc_s;
            iena    <= 1'b1;
        end else if (accept_s) begin
            iena <= 1'b0;
            // A squash refetches on the same thread, so the phase stays put.
            if (AEMB_HTX) gpha <= squash_s ? gpha : ~gpha;
            else          gpha <= 1'b0;
        end else begin
            iena <= iena;
        end
    end

endmodule
